bist_pattern_gen: RTL and testbench
===================================

# bist_pattern_gen

Parametrised built-in self-test pattern generator for router link channels; the next generation of the BIST sender. On a start request it drives TEST_CASES test patterns onto a bus of TEST_CHANNELS wires in one of four selectable modes (PRBS, walking-one, walking-zero, checkerboard), with a hold input for stalling. When the run completes, the live functional channels are passed through. It sits between the router output logic and the physical link, paired with a BIST checker at the far end.

## Interface
- TEST_CHANNELS, 70, width of channel bus (>= 1)
- LFSR_WIDTH, 32, PRBS generator width (2..64)
- SEED, 32'hdeadbeef, LFSR reset/reload value, LFSR_WIDTH bits, nonzero
- TAPS, 32'h80200003, Galois feedback mask, LFSR_WIDTH bits
- TEST_CASES, 1000, patterns per run (>= 1)
- AUTO_START, 1, 1 = leave reset directly in RUN with mode PRBS
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  run request; sampled only in IDLE or DONE
- mode  in  2  0 PRBS, 1 WALK1, 2 WALK0, 3 CHECKER; latched on start
- hold  in  1  in RUN, freezes pattern and count
- input_channels  in  TEST_CHANNELS  functional traffic
- busy  out  1  high in RUN
- ready  out  1  high in DONE
- case_count  out  $clog2(TEST_CASES+1)  patterns issued this run
- output_channels  out  TEST_CHANNELS  link drive

## Operation
- States: IDLE, RUN, DONE.
- Reset: state is RUN if AUTO_START, else IDLE. Mode is PRBS, case_count 0, pattern register 0, LFSR = SEED.
- IDLE: output_channels = '0; busy = 0; ready = 0.
- IDLE or DONE with start = 1: go to RUN, latch mode, case_count := 0, LFSR := SEED, pattern := initial value.
  - Initial value: 0 for PRBS; ...0001 for WALK1; ~...0001 for WALK0; 0101... (bit0 = 1) for CHECKER.
- RUN: output_channels = pattern register; busy = 1.
  - Each cycle with hold = 0 and case_count < TEST_CASES: pattern advances, case_count increments.
  - PRBS advance: pattern := (pattern << LFSR_WIDTH) | lfsr_out, truncated to TEST_CHANNELS. The LFSR steps in the same cycle. Galois step: n := (n >> 1) ^ (n[0] ? TAPS : 0).
  - WALK1/WALK0 advance: rotate left by 1; bit TEST_CHANNELS-1 wraps to bit 0.
  - CHECKER advance: bitwise invert.
  - When case_count equals TEST_CASES: go to DONE on the next edge. The count never exceeds TEST_CASES.
- DONE: output_channels = input_channels (combinational bypass); ready = 1; case_count holds at TEST_CASES.
- hold = 1 in RUN: pattern, LFSR and count all freeze. The output keeps the frozen pattern.
- start during RUN is ignored. hold outside RUN is ignored.
- A reset mid-run aborts immediately to the reset state. No partial-run status is retained.
- TEST_CHANNELS = 1: walking modes hold a constant value; CHECKER toggles.

## Timing
- start high at edge k in IDLE/DONE: busy = 1 after k; the initial pattern is visible in the cycle after k.
- With no hold, pattern i (i = 0 initial) is visible for one cycle each. After TEST_CASES advances, ready rises one edge after case_count reaches TEST_CASES.
- Run length without hold: TEST_CASES+1 RUN cycles. Each hold cycle adds one.
- Legacy equivalence: with AUTO_START = 1, mode PRBS and no hold, output_channels and ready are cycle-identical to the previous BIST sender.
- ready and busy are registered-state decodes; output_channels is a combinational mux on state.

## Structure
- Package bist_pkg: bist_mode_e (PRBS, WALK1, WALK0, CHECKER; 2 bits) and bist_state_e (IDLE, RUN, DONE).
- Sub-module lfsr_n, parameters WIDTH, SEED, TAPS; ports clk, reset, load, en, n. It replaces the fixed 32-bit LFSR.
- Elaboration assertions: SEED != 0, TEST_CASES >= 1, 2 <= LFSR_WIDTH <= 64.

## Test plan
- AUTO_START=0, TEST_CHANNELS=8, mode WALK1, start pulse: output 01,02,04,…,80,01 over successive cycles. With TEST_CASES=9, ready rises and output equals input_channels = 8'h3C.
- Mode CHECKER, TEST_CHANNELS=8, TEST_CASES=4: output 55,AA,55,AA,55, then bypass; case_count ends at 4.
- Mode PRBS, LFSR_WIDTH=8, SEED=8'h01, TAPS=8'hB8, TEST_CHANNELS=8: output 00, then the successive LFSR states starting 8'hB8.
- hold asserted 3 cycles mid-run in WALK0 (TEST_CHANNELS=4): output frozen at the held pattern (e.g. D), count frozen, ready delayed exactly 3 cycles.
- Reset asserted at case 5 of a run: outputs return to reset values asynchronously. A new start restarts from the initial pattern with case_count 0.
- AUTO_START=1 defaults (TEST_CHANNELS=70, TEST_CASES=1000): run compared against a golden model of the previous sender. ready is high after 1001 cycles, with the 70-bit bypass checked.

Source files
------------

// File: rtl/bist_pattern_gen_pkg.sv
// Shared types and the Galois LFSR step for the BIST pattern generator.
package bist_pkg;

  typedef enum logic [1:0] {
    PRBS    = 2'd0,
    WALK1   = 2'd1,
    WALK0   = 2'd2,
    CHECKER = 2'd3
  } bist_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  localparam int unsigned MAX_LFSR_WIDTH = 64;

  // One right-shifting Galois step; narrower LFSRs are zero-extended into it.
  function automatic logic [MAX_LFSR_WIDTH-1:0] galois_step(
    input logic [MAX_LFSR_WIDTH-1:0] n,
    input logic [MAX_LFSR_WIDTH-1:0] taps
  );
    galois_step = (n >> 1) ^ (n[0] ? taps : 64'd0);
  endfunction

endpackage

// File: rtl/bist_pattern_gen_lfsr.sv
// Width-parameterised Galois LFSR with synchronous reload to SEED.
module lfsr_n
  import bist_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'hdeadbeef),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h80200003)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] n
);

  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] n_d;

  always_comb begin
    if (load) begin
      n_d = SEED;
    end else if (en) begin
      n_d = WIDTH'(galois_step(64'(n_q), 64'(TAPS)));
    end else begin
      n_d = n_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q <= SEED;
    end else begin
      n_q <= n_d;
    end
  end

  assign n = n_q;

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST link pattern generator: PRBS / walking-one / walking-zero / checkerboard
// runs of TEST_CASES patterns, then functional bypass of input_channels.
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int                    TEST_CHANNELS = 70,
  parameter int                    LFSR_WIDTH    = 32,
  parameter logic [LFSR_WIDTH-1:0] SEED          = LFSR_WIDTH'(32'hdeadbeef),
  parameter logic [LFSR_WIDTH-1:0] TAPS          = LFSR_WIDTH'(32'h80200003),
  parameter int                    TEST_CASES    = 1000,
  parameter bit                    AUTO_START    = 1'b1,
  localparam int                   CW            = $clog2(TEST_CASES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic                     hold,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic                     busy,
  output logic                     ready,
  output logic [CW-1:0]            case_count,
  output logic [TEST_CHANNELS-1:0] output_channels
);

  localparam int PW = TEST_CHANNELS + LFSR_WIDTH;

  if (SEED == '0) begin : g_seed_chk
    $error("bist_pattern_gen: SEED must be nonzero");
  end
  if (TEST_CASES < 1) begin : g_cases_chk
    $error("bist_pattern_gen: TEST_CASES must be at least 1");
  end
  if (LFSR_WIDTH < 2 || LFSR_WIDTH > 64) begin : g_width_chk
    $error("bist_pattern_gen: LFSR_WIDTH must be within 2..64");
  end

  bist_state_e              state_q, state_d;
  bist_mode_e               mode_q, mode_d;
  logic [CW-1:0]            count_q, count_d;
  logic [TEST_CHANNELS-1:0] pattern_q, pattern_d;
  logic                     busy_q, busy_d;
  logic                     ready_q, ready_d;

  bist_mode_e               mode_in_s;
  logic                     start_s, last_s, advance_s;
  logic [LFSR_WIDTH-1:0]    lfsr_s, lfsr_next_s;
  logic [PW-1:0]            prbs_wide_s;
  logic [TEST_CHANNELS-1:0] checker_s, init_s, rotl_s;

  for (genvar i = 0; i < TEST_CHANNELS; i++) begin : g_checker
    assign checker_s[i] = ((i % 2) == 0) ? 1'b1 : 1'b0;
  end

  lfsr_n #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (start_s),
    .en    (advance_s && (mode_q == PRBS)),
    .n     (lfsr_s)
  );

  // The new PRBS word is the LFSR value after this cycle's step.
  always_comb begin
    mode_in_s   = bist_mode_e'(mode);
    start_s     = start && ((state_q == IDLE) || (state_q == DONE));
    last_s      = (count_q == CW'(TEST_CASES));
    advance_s   = (state_q == RUN) && !hold && !last_s;
    lfsr_next_s = LFSR_WIDTH'(galois_step(64'(lfsr_s), 64'(TAPS)));
    prbs_wide_s = {pattern_q, {LFSR_WIDTH{1'b0}}} | PW'(lfsr_next_s);
    rotl_s      = (pattern_q << 1) | (pattern_q >> (TEST_CHANNELS - 1));
    case (mode_in_s)
      PRBS:    init_s = '0;
      WALK1:   init_s = TEST_CHANNELS'(1);
      WALK0:   init_s = ~TEST_CHANNELS'(1);
      CHECKER: init_s = checker_s;
      default: init_s = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    count_d   = count_q;
    pattern_d = pattern_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_s) begin
          state_d   = RUN;
          mode_d    = mode_in_s;
          count_d   = '0;
          pattern_d = init_s;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (last_s) begin
          state_d = DONE;
        end else if (advance_s) begin
          count_d = count_q + CW'(1);
          case (mode_q)
            PRBS:         pattern_d = prbs_wide_s[TEST_CHANNELS-1:0];
            WALK1, WALK0: pattern_d = rotl_s;
            CHECKER:      pattern_d = ~pattern_q;
            default:      pattern_d = pattern_q;
          endcase
        end else begin
          pattern_d = pattern_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == RUN);
    ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= AUTO_START ? RUN : IDLE;
      mode_q    <= PRBS;
      count_q   <= '0;
      pattern_q <= '0;
      busy_q    <= AUTO_START;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      pattern_q <= pattern_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  // Link drive switches to functional traffic the moment the run is done.
  always_comb begin
    case (state_q)
      RUN:     output_channels = pattern_q;
      DONE:    output_channels = input_channels;
      default: output_channels = '0;
    endcase
  end

  assign busy       = busy_q;
  assign ready      = ready_q;
  assign case_count = count_q;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Self-checking bench: three small configurations plus the legacy default.
module tb_bist_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: 8 channels, 8-bit LFSR, 9 cases
  logic       a_start, a_hold, a_busy, a_ready;
  logic [1:0] a_mode;
  logic [7:0] a_in, a_out;
  logic [3:0] a_cnt;

  bist_pattern_gen #(
    .TEST_CHANNELS(8), .LFSR_WIDTH(8), .SEED(8'h01), .TAPS(8'hB8),
    .TEST_CASES(9), .AUTO_START(1'b0)
  ) u_a (
    .clk(clk), .reset(rst), .start(a_start), .mode(a_mode), .hold(a_hold),
    .input_channels(a_in), .busy(a_busy), .ready(a_ready),
    .case_count(a_cnt), .output_channels(a_out)
  );

  // Instance C: single channel, 3 cases
  logic       c_start, c_hold, c_busy, c_ready, c_in, c_out;
  logic [1:0] c_mode;
  logic [1:0] c_cnt;

  bist_pattern_gen #(
    .TEST_CHANNELS(1), .LFSR_WIDTH(8), .SEED(8'h01), .TAPS(8'hB8),
    .TEST_CASES(3), .AUTO_START(1'b0)
  ) u_c (
    .clk(clk), .reset(rst), .start(c_start), .mode(c_mode), .hold(c_hold),
    .input_channels(c_in), .busy(c_busy), .ready(c_ready),
    .case_count(c_cnt), .output_channels(c_out)
  );

  // Instance D: default parameters, auto-start legacy behaviour
  logic        d_start, d_hold, d_busy, d_ready;
  logic [1:0]  d_mode;
  logic [69:0] d_in, d_out;
  logic [9:0]  d_cnt;

  bist_pattern_gen u_d (
    .clk(clk), .reset(rst), .start(d_start), .mode(d_mode), .hold(d_hold),
    .input_channels(d_in), .busy(d_busy), .ready(d_ready),
    .case_count(d_cnt), .output_channels(d_out)
  );

  // Expected pattern number i of a run, from the pattern definitions directly.
  function automatic logic [127:0] exp_pat(input int md, input int i, input int n,
                                           input int lw, input logic [63:0] seed,
                                           input logic [63:0] taps);
    logic [191:0] acc;
    logic [191:0] mask;
    logic [63:0]  s;
    mask = (192'd1 << n) - 192'd1;
    acc  = '0;
    case (md)
      0: begin
        s = seed;
        for (int k = 1; k <= i; k++) begin
          s = (s >> 1) ^ (s[0] ? taps : 64'd0);
          if ((i - k) * lw < n) acc = acc | (192'(s) << ((i - k) * lw));
        end
      end
      1: acc = 192'd1 << (i % n);
      2: acc = ~(192'd1 << (i % n));
      default: for (int b = 0; b < n; b++) acc[b] = (((b + i) % 2) == 0);
    endcase
    return 128'(acc & mask);
  endfunction

  // One complete run on instance A with optional random or fixed hold.
  task automatic run_a(input logic [1:0] md, input int hold_pct, input int hold_at,
                       input bit noisy, input string tag);
    int idx, held, guard;
    bit h;
    logic [127:0] e;
    @(negedge clk);
    a_mode = md; a_start = 1'b1; a_hold = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    idx = 0; held = 0; guard = 0;
    while (guard < 100) begin
      e = exp_pat(int'(md), idx, 8, 8, 64'h01, 64'hB8);
      checks++;
      if (a_busy !== 1'b1 || a_ready !== 1'b0 || a_cnt !== 4'(idx) || a_out !== e[7:0]) begin
        errors++;
        $display("FAIL %s run idx=%0d: busy=%b ready=%b cnt=%0d out=%h, required busy=1 ready=0 cnt=%0d out=%h",
                 tag, idx, a_busy, a_ready, a_cnt, a_out, idx, e[7:0]);
      end
      if (idx == 9) break;
      h = ((idx == hold_at) && (held < 3)) || ($urandom_range(99) < hold_pct);
      if (h && idx == hold_at) held++;
      a_hold = h;
      a_in   = 8'($urandom);
      if (noisy) begin
        a_start = 1'($urandom_range(1));
        a_mode  = 2'($urandom);
      end
      @(negedge clk);
      if (!h) idx++;
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL %s timeout: idx=%0d after %0d cycles, required idx=9", tag, idx, guard);
    end
    a_hold = 1'b0; a_start = 1'b0;
    @(negedge clk);
    a_hold = 1'b1;
    a_in   = 8'($urandom);
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_ready !== 1'b1 || a_cnt !== 4'd9 || a_out !== a_in) begin
      errors++;
      $display("FAIL %s done: busy=%b ready=%b cnt=%0d out=%h, required busy=0 ready=1 cnt=9 out=%h",
               tag, a_busy, a_ready, a_cnt, a_out, a_in);
    end
    @(negedge clk);
    a_hold = 1'b0;
    checks++;
    if (a_ready !== 1'b1 || a_cnt !== 4'd9) begin
      errors++;
      $display("FAIL %s done_stays: ready=%b cnt=%0d, required ready=1 cnt=9", tag, a_ready, a_cnt);
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_cnt !== 4'd0 || a_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: busy=%b ready=%b cnt=%0d out=%h, required 0 0 0 00", a_busy, a_ready, a_cnt, a_out);
    end
    checks++;
    if (c_busy !== 1'b0 || c_ready !== 1'b0 || c_cnt !== 2'd0 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_one_ch: busy=%b ready=%b cnt=%0d out=%b, required 0 0 0 0", c_busy, c_ready, c_cnt, c_out);
    end
    checks++;
    if (d_busy !== 1'b1 || d_ready !== 1'b0 || d_cnt !== 10'd0 || d_out !== 70'd0) begin
      errors++;
      $display("FAIL reset_auto: busy=%b ready=%b cnt=%0d out=%h, required 1 0 0 0", d_busy, d_ready, d_cnt, d_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_walk1;
    run_a(2'd1, 0, -1, 1'b0, "walk1");
    a_in = 8'h3C;
    #1;
    checks++;
    if (a_out !== 8'h3C) begin
      errors++;
      $display("FAIL walk1_bypass: out=%h, required 3c", a_out);
    end
  endtask

  task automatic test_back_to_back;
    run_a(2'd3, 0, -1, 1'b0, "b2b_checker");
    run_a(2'd0, 0, -1, 1'b0, "b2b_prbs");
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) run_a(2'($urandom), 25, -1, 1'b1, "random");
  endtask

  task automatic test_reset_midrun;
    int guard;
    guard = 0;
    @(negedge clk);
    a_mode = 2'd1; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    while (a_cnt !== 4'd5 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL midrun_wait: cnt=%0d, required 5", a_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_cnt !== 4'd0 || a_out !== 8'h00) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b ready=%b cnt=%0d out=%h, required 0 0 0 00", a_busy, a_ready, a_cnt, a_out);
    end
    @(negedge clk);
    rst = 1'b0;
    run_a(2'd1, 0, -1, 1'b0, "restart");
  endtask

  task automatic test_one_channel;
    logic [127:0] e;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      c_mode = 2'(m); c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      for (int i = 0; i <= 3; i++) begin
        e = exp_pat(m, i, 1, 8, 64'h01, 64'hB8);
        checks++;
        if (c_busy !== 1'b1 || c_cnt !== 2'(i) || c_out !== e[0]) begin
          errors++;
          $display("FAIL one_ch mode=%0d idx=%0d: busy=%b cnt=%0d out=%b, required 1 %0d %b",
                   m, i, c_busy, c_cnt, c_out, i, e[0]);
        end
        @(negedge clk);
      end
      c_in = 1'($urandom);
      #1;
      checks++;
      if (c_ready !== 1'b1 || c_cnt !== 2'd3 || c_out !== c_in) begin
        errors++;
        $display("FAIL one_ch_done mode=%0d: ready=%b cnt=%0d out=%b, required 1 3 %b", m, c_ready, c_cnt, c_out, c_in);
      end
    end
  endtask

  task automatic test_legacy;
    logic [127:0] e;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= 1000; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_pat(0, i, 70, 32, 64'hdeadbeef, 64'h80200003);
      checks++;
      if (d_busy !== 1'b1 || d_ready !== 1'b0 || d_cnt !== 10'(i) || d_out !== e[69:0]) begin
        errors++;
        $display("FAIL legacy idx=%0d: busy=%b ready=%b cnt=%0d out=%h, required 1 0 %0d %h",
                 i, d_busy, d_ready, d_cnt, d_out, i, e[69:0]);
      end
    end
    @(negedge clk);
    d_in = 70'({$urandom, $urandom, $urandom});
    #1;
    checks++;
    if (d_busy !== 1'b0 || d_ready !== 1'b1 || d_cnt !== 10'd1000 || d_out !== d_in) begin
      errors++;
      $display("FAIL legacy_done: busy=%b ready=%b cnt=%0d out=%h, required 0 1 1000 %h",
               d_busy, d_ready, d_cnt, d_out, d_in);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_hold = 1'b0; a_mode = 2'd0; a_in = 8'h00;
    c_start = 1'b0; c_hold = 1'b0; c_mode = 2'd0; c_in = 1'b0;
    d_start = 1'b0; d_hold = 1'b0; d_mode = 2'd0; d_in = 70'd0;
    test_reset;
    test_walk1;
    run_a(2'd3, 0, -1, 1'b0, "checker");
    run_a(2'd0, 0, -1, 1'b0, "prbs");
    run_a(2'd2, 0, 3, 1'b0, "walk0_hold");
    test_back_to_back;
    test_random;
    test_reset_midrun;
    test_one_channel;
    test_legacy;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
